// File: rtl/func_scheduler_if.sv
// func_scheduler_if: request and response channels of the job scheduler
//   req_*  : producer pushes (a, b, tag); req_ready is high while the FIFO has space
//   rsp_*  : consumer accepts (data, tag) on rsp_valid && rsp_ready
//   master : producer/consumer side, slave : scheduler side
interface func_scheduler_if #(
    parameter int TAG_W = 2
);
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_a;
    logic [7:0]       req_b;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [9:0]       rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/func_scheduler.sv
// func_scheduler: FIFO-buffered job issuer in front of the functions unit
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : request/response channels (func_scheduler_if.slave)
//   fu_start  : one-cycle start pulse; fu_a/fu_b held from issue until the next pop
//   fu_busy   : unit busy; fu_out is sampled the cycle busy is seen low in RUN
//   jobs_done : completed-job counter, wraps
module func_scheduler #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    func_scheduler_if.slave bus,
    output logic            fu_start,
    output logic [7:0]      fu_a,
    output logic [7:0]      fu_b,
    input  logic            fu_busy,
    input  logic [9:0]      fu_out,
    output logic [15:0]     jobs_done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK, RUN} state_t;

    state_t           state;
    logic [7:0]       mem_a [DEPTH];
    logic [7:0]       mem_b [DEPTH];
    logic [TAG_W-1:0] mem_t [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      count;
    logic [TAG_W-1:0] tag;
    logic             push;
    logic             pop;

    // readiness comes from the registered count only, so a same-cycle pop never frees a slot early
    assign bus.req_ready = count != (AW+1)'(DEPTH);
    assign push = bus.req_valid && bus.req_ready;
    // the response slot counts as free when it is empty or being drained this cycle
    assign pop = state == IDLE && count != '0 && (!bus.rsp_valid || bus.rsp_ready);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wp] <= bus.req_a;
            mem_b[wp] <= bus.req_b;
            mem_t[wp] <= bus.req_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wp            <= '0;
            rp            <= '0;
            count         <= '0;
            tag           <= '0;
            fu_start      <= 1'b0;
            fu_a          <= '0;
            fu_b          <= '0;
            jobs_done     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_tag   <= '0;
        end else begin
            fu_start <= 1'b0;
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push)
                wp <= wp + AW'(1);
            if (bus.rsp_valid && bus.rsp_ready)
                bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    rp       <= rp + AW'(1);
                    fu_a     <= mem_a[rp];
                    fu_b     <= mem_b[rp];
                    tag      <= mem_t[rp];
                    fu_start <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: state <= ACK;
                ACK: if (fu_busy) state <= RUN;
                RUN: if (!fu_busy) begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_data  <= fu_out;
                    bus.rsp_tag   <= tag;
                    jobs_done     <= jobs_done + 16'd1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
